// File: rtl/servo_pkg.sv
// Shared constants and types for the servo sequencing blocks.
package servo_pkg;

  // Default magnitude width; matches the servo PWM magnitude input.
  localparam int SERVO_MAG_W    = 17;

  // Upper clamp on any commanded target (95% duty equivalent).
  localparam int SERVO_MAG_MAX  = 22800;

  // Default clk cycles per update tick: one 20 ms servo frame at 50 MHz.
  localparam int SERVO_TICK_DIV = 1000000;

  // One channel magnitude at the default width.
  typedef logic [SERVO_MAG_W-1:0] mag_t;

  // Sequencer states: accepting commands, or walking the channels once per tick.
  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

endpackage

// File: rtl/servo_tick_gen.sv
// Free-running frame divider. The counter runs 0..TICK_DIV-1 and the tick
// output is high for exactly the one cycle in which the counter sits at its
// last value (the cycle that ends with the wrap). TICK_DIV must be >= 2.
module servo_tick_gen
  import servo_pkg::*;
#(
  parameter int TICK_DIV = SERVO_TICK_DIV,
  parameter int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(TICK_DIV - 2);

  logic [CNT_W-1:0] cnt_q;

  // Frame counter: wraps back to zero after its last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Registered tick, raised one cycle early so it lines up with the wrap cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick <= 1'b0;
    end else begin
      tick <= (cnt_q == PRE_LAST);
    end
  end

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Multi-channel servo position sequencer.
// Commands load a clamped target and a slew step per channel while the
// controller is idle. Each frame tick starts a sweep that updates one channel
// per cycle (0..NUM_CH-1), moving its current magnitude toward the target by
// at most one step. The current magnitudes drive the PWM blocks directly.
// TICK_DIV must exceed NUM_CH so a tick never lands inside a sweep.
module servo_ramp_ctrl
  import servo_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int MAG_W    = SERVO_MAG_W,
  parameter int MAG_MAX  = SERVO_MAG_MAX,
  parameter int TICK_DIV = SERVO_TICK_DIV,
  parameter int CH_W     = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [CH_W-1:0]         cmd_ch,
  input  logic [MAG_W-1:0]        cmd_target,
  input  logic [MAG_W-1:0]        cmd_step,
  output logic [NUM_CH*MAG_W-1:0] mag_out,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic                    tick_out
);

  localparam logic [MAG_W-1:0] MAG_LIMIT = MAG_W'(MAG_MAX);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);

  state_e           state_q;
  logic [CH_W-1:0]  sweep_idx_q;
  logic             tick;
  logic             accept;
  logic [MAG_W-1:0] tgt_clamped;

  logic [MAG_W-1:0] cur_q    [NUM_CH];
  logic [MAG_W-1:0] tgt_q    [NUM_CH];
  logic [MAG_W-1:0] step_q   [NUM_CH];
  logic [MAG_W-1:0] cur_nxt  [NUM_CH];
  logic [MAG_W-1:0] tgt_nxt  [NUM_CH];
  logic [MAG_W-1:0] step_nxt [NUM_CH];
  logic [NUM_CH-1:0] busy_nxt;
  logic [NUM_CH-1:0] done_nxt;

  // One slew step toward the target. Arithmetic is one bit wider than the
  // magnitude so a large step can neither wrap past zero nor past full scale;
  // any step that would reach or cross the target lands exactly on it, and a
  // zero step means jump straight to the target.
  function automatic logic [MAG_W-1:0] ramp_step(
    input logic [MAG_W-1:0] cur,
    input logic [MAG_W-1:0] tgt,
    input logic [MAG_W-1:0] step
  );
    logic [MAG_W:0] sum;
    logic [MAG_W:0] diff;
    sum  = {1'b0, cur} + {1'b0, step};
    diff = {1'b0, cur} - {1'b0, step};
    ramp_step = cur;
    if (cur < tgt) begin
      if ((step == '0) || (sum >= {1'b0, tgt})) begin
        ramp_step = tgt;
      end else begin
        ramp_step = sum[MAG_W-1:0];
      end
    end else if (cur > tgt) begin
      if ((step == '0) || diff[MAG_W] || (diff <= {1'b0, tgt})) begin
        ramp_step = tgt;
      end else begin
        ramp_step = diff[MAG_W-1:0];
      end
    end
  endfunction

  servo_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign tick_out = tick;

  // Handshake and target clamp; ready is only ever high while idle.
  always_comb begin
    accept      = cmd_valid & cmd_ready;
    tgt_clamped = (cmd_target > MAG_LIMIT) ? MAG_LIMIT : cmd_target;
  end

  // Next channel state: commands rewrite target/step (out-of-range channels
  // match nothing and are dropped); the sweep updates the selected channel and
  // flags done only when this update actually brings it onto its target.
  always_comb begin
    done_nxt = '0;
    busy_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cur_nxt[i]  = cur_q[i];
      tgt_nxt[i]  = tgt_q[i];
      step_nxt[i] = step_q[i];
      if (accept && (cmd_ch == CH_W'(i))) begin
        tgt_nxt[i]  = tgt_clamped;
        step_nxt[i] = cmd_step;
      end
      if ((state_q == SWEEP) && (sweep_idx_q == CH_W'(i))) begin
        cur_nxt[i]  = ramp_step(cur_q[i], tgt_q[i], step_q[i]);
        done_nxt[i] = (cur_q[i] != tgt_q[i]) && (cur_nxt[i] == tgt_q[i]);
      end
      busy_nxt[i] = (cur_nxt[i] != tgt_nxt[i]);
    end
  end

  // Channel registers plus the registered busy and done flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cur_q[i]  <= '0;
        tgt_q[i]  <= '0;
        step_q[i] <= '0;
      end
      busy <= '0;
      done <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cur_q[i]  <= cur_nxt[i];
        tgt_q[i]  <= tgt_nxt[i];
        step_q[i] <= step_nxt[i];
      end
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  // Sequencer: a tick while idle starts a sweep of NUM_CH cycles, during
  // which commands are held off; ready returns on the cycle after the last
  // channel has been written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sweep_idx_q <= '0;
      cmd_ready   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick) begin
            state_q     <= SWEEP;
            sweep_idx_q <= '0;
            cmd_ready   <= 1'b0;
          end
        end
        SWEEP: begin
          if (sweep_idx_q == LAST_CH) begin
            state_q     <= IDLE;
            sweep_idx_q <= '0;
            cmd_ready   <= 1'b1;
          end else begin
            sweep_idx_q <= sweep_idx_q + CH_W'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          sweep_idx_q <= '0;
          cmd_ready   <= 1'b1;
        end
      endcase
    end
  end

  // Current magnitudes packed onto the output bus, channel 0 in the LSBs.
  always_comb begin
    mag_out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mag_out[i*MAG_W +: MAG_W] = cur_q[i];
    end
  end

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Directed bench for servo_ramp_ctrl with a magnitude-change scoreboard.
module tb_servo_ramp_ctrl;
  import servo_pkg::*;

  localparam int NUM_CH   = 4;
  localparam int MAG_W    = SERVO_MAG_W;
  localparam int TICK_DIV = 16;
  localparam int CH_W     = 2;

  typedef struct {
    int   ch;
    mag_t mag;
  } exp_t;

  logic                    clk;
  logic                    reset;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [CH_W-1:0]         cmd_ch;
  logic [MAG_W-1:0]        cmd_target;
  logic [MAG_W-1:0]        cmd_step;
  logic [NUM_CH*MAG_W-1:0] mag_out;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;
  logic                    tick_out;

  int   n_assert;
  int   n_fail;
  int   done_cnt [NUM_CH];
  int   done_total;
  exp_t sb_q [$];
  mag_t prev_mag [NUM_CH];

  servo_ramp_ctrl #(
    .NUM_CH   (NUM_CH),
    .MAG_W    (MAG_W),
    .MAG_MAX  (SERVO_MAG_MAX),
    .TICK_DIV (TICK_DIV),
    .CH_W     (CH_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ch     (cmd_ch),
    .cmd_target (cmd_target),
    .cmd_step   (cmd_step),
    .mag_out    (mag_out),
    .busy       (busy),
    .done       (done),
    .tick_out   (tick_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mag_t mag_ch(input int i);
    return mag_out[i*MAG_W +: MAG_W];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic pushExpect(input int ch, input int mag);
    exp_t e;
    e.ch  = ch;
    e.mag = mag_t'(mag);
    sb_q.push_back(e);
  endtask

  task automatic applyStimulus(input int ch, input int target, input int step);
    int waited;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_ch     = CH_W'(ch);
    cmd_target = MAG_W'(target);
    cmd_step   = MAG_W'(step);
    waited     = 0;
    while (!cmd_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("accept_in_time", (waited < 100), 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitTick(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!tick_out && cycles < 200);
    checkOutput("tick_seen", tick_out, 1);
    checkOutput("tick_in_idle", cmd_ready, 1);
  endtask

  task automatic waitQueue(input int size, input string tag);
    int n;
    n = 0;
    while (sb_q.size() > size && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, sb_q.size(), size);
  endtask

  // Scoreboard monitor: every channel magnitude change must match the next
  // queued expectation; done pulses are tallied per channel.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (mag_ch(i) !== prev_mag[i]) begin
          if (sb_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("[TB] FAIL unexpected_mag ch%0d observed %0d expected no change", i, mag_ch(i));
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            n_assert++;
            assert (i === e.ch) else begin
              n_fail++;
              $error("[TB] FAIL sb_channel observed %0d expected %0d", i, e.ch);
            end
            n_assert++;
            assert (mag_ch(i) === e.mag) else begin
              n_fail++;
              $error("[TB] FAIL sb_mag ch%0d observed %0d expected %0d", i, mag_ch(i), e.mag);
            end
          end
        end
        if (done[i] === 1'b1) begin
          done_cnt[i]++;
          done_total++;
        end
      end
    end
    for (int i = 0; i < NUM_CH; i++) prev_mag[i] = mag_ch(i);
  end

  initial begin
    int cyc;
    int lowc;
    int done_snap;
    n_assert   = 0;
    n_fail     = 0;
    done_total = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      done_cnt[i] = 0;
      prev_mag[i] = '0;
    end
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_ch     = '0;
    cmd_target = '0;
    cmd_step   = '0;

    // Reset release, then three idle ticks
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_mag", (mag_out == '0), 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_tick", tick_out, 0);
    checkOutput("rst_ready", cmd_ready, 1);
    waitTick(cyc);
    waitTick(cyc);
    checkOutput("tick_period_a", cyc, TICK_DIV);
    waitTick(cyc);
    checkOutput("tick_period_b", cyc, TICK_DIV);
    waitCycles(6);
    checkOutput("idle_mag", (mag_out == '0), 1);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_done_total", done_total, 0);
    checkOutput("idle_ready", cmd_ready, 1);

    // ch1 ramp 0 -> 1000 in steps of 300
    $display("[TB] ch1 ramp");
    pushExpect(1, 300);
    pushExpect(1, 600);
    pushExpect(1, 900);
    pushExpect(1, 1000);
    applyStimulus(1, 1000, 300);
    checkOutput("ch1_busy_set", busy[1], 1);
    waitQueue(0, "ch1_ramp_complete");
    waitCycles(2);
    checkOutput("ch1_done_once", done_cnt[1], 1);
    checkOutput("ch1_busy_fell", busy[1], 0);
    checkOutput("ch1_final", mag_ch(1), 1000);

    // ch0 jump with clamp
    $display("[TB] ch0 clamp");
    pushExpect(0, 22800);
    applyStimulus(0, 50000, 0);
    waitQueue(0, "ch0_jump_complete");
    waitCycles(2);
    checkOutput("ch0_done", done_cnt[0], 1);
    checkOutput("ch0_busy", busy[0], 0);

    // ch2 retarget downward mid-ramp
    $display("[TB] ch2 retarget");
    pushExpect(2, 1000);
    applyStimulus(2, 1500, 1000);
    waitQueue(0, "ch2_first_step");
    checkOutput("ch2_done_none", done_cnt[2], 0);
    pushExpect(2, 500);
    pushExpect(2, 200);
    applyStimulus(2, 200, 500);
    checkOutput("ch2_busy_mid", busy[2], 1);
    waitQueue(0, "ch2_ramp_down");
    waitCycles(2);
    checkOutput("ch2_done", done_cnt[2], 1);
    checkOutput("ch2_busy", busy[2], 0);

    // Command presented on the tick cycle, second command held through the sweep
    $display("[TB] tick-cycle command");
    pushExpect(3, 400);
    pushExpect(1, 0);
    waitTick(cyc);
    cmd_valid  = 1'b1;
    cmd_ch     = CH_W'(3);
    cmd_target = MAG_W'(400);
    cmd_step   = '0;
    @(posedge clk);
    #1;
    cmd_ch     = CH_W'(1);
    cmd_target = '0;
    cmd_step   = '0;
    lowc = 0;
    @(negedge clk);
    while (!cmd_ready && lowc < 20) begin
      lowc++;
      @(negedge clk);
    end
    checkOutput("ready_low_cycles", lowc, NUM_CH);
    checkOutput("tickcmd_applied", mag_ch(3), 400);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    checkOutput("held_cmd_busy", busy[1], 1);
    waitQueue(0, "held_cmd_applied");
    waitCycles(2);
    checkOutput("ch3_done", done_cnt[3], 1);
    checkOutput("ch1_done_again", done_cnt[1], 2);

    // Reset in the middle of a sweep while ch3 ramps
    $display("[TB] reset mid-sweep");
    pushExpect(3, 500);
    pushExpect(3, 600);
    applyStimulus(3, 20000, 100);
    waitQueue(1, "ch3_first_step");
    waitTick(cyc);
    @(negedge clk);
    done_snap = done_total;
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_mag", (mag_out == '0), 1);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_ready", cmd_ready, 1);
    sb_q.delete();
    waitCycles(2);
    #2 reset = 1'b0;
    waitCycles(3);
    checkOutput("post_rst_no_done", done_total, done_snap);
    checkOutput("post_rst_mag", (mag_out == '0), 1);
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_ready", cmd_ready, 1);
    pushExpect(3, 100);
    applyStimulus(3, 100, 0);
    waitQueue(0, "post_rst_cmd");
    waitCycles(2);
    checkOutput("post_rst_done", done_cnt[3], 2);
    checkOutput("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
